// File: rtl/logic_unit_serial.sv
// Bit-serial bitwise logic unit: one of eight logic ops, SLICE bits per clock.
// Operands are latched on accept; the result and its flags are held until taken.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operation handshake (ready only when idle)
//   op, a, b             opcode and operands (b unused for NOT/PASS)
//   out_valid, out_ready result handshake (valid only when done)
//   y, zero, all_ones    registered result and its flags
module logic_unit_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             all_ones
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("logic_unit_serial: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             ones_q;

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] sr;
    logic [WIDTH-1:0] acc_d;
    logic             last;

    // Select the operand slice addressed by the counter.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CW'(i)) begin
                sa = a_q[i*SLICE +: SLICE];
                sb = b_q[i*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        sr = '0;
        unique case (op_q)
            3'b000: sr = sa & sb;
            3'b001: sr = sa | sb;
            3'b010: sr = sa ^ sb;
            3'b011: sr = ~(sa & sb);
            3'b100: sr = ~(sa | sb);
            3'b101: sr = ~(sa ^ sb);
            3'b110: sr = ~sa;
            3'b111: sr = sa;
        endcase
    end

    // Accumulator with this cycle's slice merged in; on the last slice this
    // is the complete result, so it feeds y directly.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CW'(i)) begin
                acc_d[i*SLICE +: SLICE] = sr;
            end
        end
    end

    assign last = (cnt_q == CW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            zero_q  <= 1'b0;
            ones_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    if (last) begin
                        y_q     <= acc_d;
                        zero_q  <= (acc_d == '0);
                        ones_q  <= &acc_d;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign zero      = zero_q;
    assign all_ones  = ones_q;

endmodule

// File: tb/tb_logic_unit_serial.sv
// Scoreboard bench for logic_unit_serial: three instances (32/8, 8/8, 8/2).
// Expected results come from a plain bitwise model pushed on each accept.
module tb_logic_unit_serial;

    typedef struct {
        logic [31:0] y;
        logic        z;
        logic        o;
        int          t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  iv;
    logic [2:0]  orr;
    logic [2:0]  opv [3];
    logic [31:0] av  [3];
    logic [31:0] bv  [3];
    wire  [2:0]  ir;
    wire  [2:0]  ov;
    wire  [2:0]  zf;
    wire  [2:0]  of;
    wire  [31:0] y0;
    wire  [7:0]  y1;
    wire  [7:0]  y2;
    logic [31:0] yv  [3];

    int   checks;
    int   failures;
    int   cyc;
    bit   done;
    exp_t q [3][$];
    bit   prev_ov [3];
    bit   popped  [3];

    int NS [3] = '{4, 1, 4};
    int WD [3] = '{32, 8, 8};

    logic_unit_serial #(.WIDTH(32), .SLICE(8)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .op(opv[0]), .a(av[0]), .b(bv[0]),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .y(y0), .zero(zf[0]), .all_ones(of[0])
    );

    logic_unit_serial #(.WIDTH(8), .SLICE(8)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .op(opv[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .y(y1), .zero(zf[1]), .all_ones(of[1])
    );

    logic_unit_serial #(.WIDTH(8), .SLICE(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]),
        .op(opv[2]), .a(av[2][7:0]), .b(bv[2][7:0]),
        .out_valid(ov[2]), .out_ready(orr[2]),
        .y(y2), .zero(zf[2]), .all_ones(of[2])
    );

    always_comb begin
        yv[0] = y0;
        yv[1] = {24'h0, y1};
        yv[2] = {24'h0, y2};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mask_of(input int w);
        logic [31:0] m;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        return m;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] z,
                                          input int w);
        logic [31:0] r;
        case (o)
            3'd0: r = x & z;
            3'd1: r = x | z;
            3'd2: r = x ^ z;
            3'd3: r = ~(x & z);
            3'd4: r = ~(x | z);
            3'd5: r = ~(x ^ z);
            3'd6: r = ~x;
            default: r = x;
        endcase
        return r & mask_of(w);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: push on accept, compare and pop on result handshake.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] r;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                q[d].delete();
                prev_ov[d] = 1'b0;
                popped[d]  = 1'b0;
            end else begin
                if (iv[d] && ir[d]) begin
                    r   = model(opv[d], av[d], bv[d], WD[d]);
                    e.y = r;
                    e.z = (r == 32'h0);
                    e.o = (r == mask_of(WD[d]));
                    e.t = cyc + 1;
                    q[d].push_back(e);
                end
                if (ov[d]) begin
                    if (q[d].size() == 0) begin
                        chk($sformatf("spurious_valid%0d", d), 32'd1, 32'd0);
                    end else begin
                        e = q[d][0];
                        if (!prev_ov[d])
                            chk($sformatf("latency%0d", d), cyc - e.t, NS[d]);
                        chk($sformatf("rdy_in_done%0d", d), {31'h0, ir[d]}, 32'h0);
                        chk($sformatf("y%0d", d), yv[d], e.y);
                        chk($sformatf("zero%0d", d), {31'h0, zf[d]}, {31'h0, e.z});
                        chk($sformatf("ones%0d", d), {31'h0, of[d]}, {31'h0, e.o});
                        if (orr[d]) begin
                            void'(q[d].pop_front());
                            popped[d] = 1'b1;
                        end
                    end
                end else begin
                    if (popped[d]) begin
                        chk($sformatf("rdy_after%0d", d), {31'h0, ir[d]}, 32'h1);
                        popped[d] = 1'b0;
                    end
                    if (q[d].size() != 0 && q[d][0].t <= cyc)
                        chk($sformatf("rdy_busy%0d", d), {31'h0, ir[d]}, 32'h0);
                end
                prev_ov[d] = ov[d];
            end
        end
    end

    task automatic issue(input int d, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] z);
        int n;
        n = 0;
        while (!ir[d] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ir[d]) chk($sformatf("issue_timeout%0d", d), 32'd0, 32'd1);
        iv[d]  = 1'b1;
        opv[d] = o;
        av[d]  = x;
        bv[d]  = z;
        @(posedge clk);
        #1;
        iv[d]  = 1'b0;
        opv[d] = 3'($urandom);
        av[d]  = $urandom;
        bv[d]  = $urandom;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (!(q[d].size() == 0 && ir[d]) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(q[d].size() == 0 && ir[d]))
            chk($sformatf("idle_timeout%0d", d), 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input int d);
        int n;
        n = 0;
        while (!ov[d] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ov[d]) chk($sformatf("valid_timeout%0d", d), 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        done     = 1'b0;
        rst_n    = 1'b0;
        iv       = '0;
        orr      = '1;
        for (int d = 0; d < 3; d++) begin
            opv[d] = '0;
            av[d]  = '0;
            bv[d]  = '0;
        end
        #23;
        chk("rst_in_ready", {31'h0, ir[0]}, 32'h1);
        chk("rst_out_valid", {31'h0, ov[0]}, 32'h0);
        chk("rst_y", y0, 32'h0);
        chk("rst_zero", {31'h0, zf[0]}, 32'h0);
        chk("rst_ones", {31'h0, of[0]}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 3'b000, 32'hFFFF0000, 32'hFF00FF00);
        wait_idle(0);

        issue(0, 3'b010, 32'hFFFF0000, 32'hFF00FF00);
        issue(0, 3'b100, 32'h0, 32'h0);
        wait_idle(0);

        orr[0] = 1'b0;
        issue(0, 3'b011, 32'hAAAAAAAA, 32'hFFFFFFFF);
        wait_valid(0);
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'($urandom);
            av[0] = $urandom;
            bv[0] = $urandom;
            @(posedge clk);
            #1;
            chk("bp_valid", {31'h0, ov[0]}, 32'h1);
            chk("bp_ready", {31'h0, ir[0]}, 32'h0);
            chk("bp_y", y0, 32'h55555555);
        end
        iv[0]  = 1'b0;
        orr[0] = 1'b1;
        wait_idle(0);

        issue(0, 3'b111, 32'h12345678, 32'h0);
        for (int i = 0; i < 4; i++) begin
            av[0] = 32'hDEADBEEF;
            opv[0] = 3'b000;
            @(posedge clk);
            #1;
        end
        wait_idle(0);
        issue(0, 3'b110, 32'h0, 32'h0);
        wait_idle(0);

        issue(0, 3'b010, 32'h0000FFFF, 32'h00FF00FF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'h0, ov[0]}, 32'h0);
        chk("abort_ready", {31'h0, ir[0]}, 32'h1);
        chk("abort_y", y0, 32'h0);
        chk("abort_ones", {31'h0, of[0]}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 3'b101, 32'h0F0F0F0F, 32'h0F0F0F0F);
        wait_idle(0);

        issue(1, 3'b001, 32'h0F, 32'hF0);
        wait_idle(1);
        issue(2, 3'b000, 32'h00, $urandom);
        wait_idle(2);

        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    issue($urandom_range(0, 2), 3'($urandom),
                          $urandom, $urandom);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2;
                    orr = 3'($urandom);
                end
                orr = '1;
            end
        join
        for (int d = 0; d < 3; d++) wait_idle(d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
